zeta_stream_sched: RTL
======================

Name: zeta_stream_sched

Overview:
- Time-shares one branch-style stream datapath (3-stage pipeline with internal feedback) among NUM_REQ requesters.
- Grants whole bursts with round-robin arbitration and feeds the granted requester's words into the datapath.
- Drains and flushes the datapath's feedback state between bursts, so one requester's data never contaminates another's results.
- Tags each datapath result with its owner and a valid flag.

Parameters:
- WIDTH, 16, data word width; matches the datapath.
- NUM_REQ, 4, number of requesters (2..8).
- BURST_MAX, 8, maximum beats per grant (1..255).
- DRAIN_CYCLES, 2, zero-input cycles after the last beat, before the flush (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester word valid.
- req_last  in  NUM_REQ  per-requester end-of-burst marker, qualified by valid.
- req_data  in  NUM_REQ*WIDTH  packed words; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- dp_stream  out  WIDTH  registered word driven into the datapath stream input.
- dp_rst_n  out  1  datapath reset; equals rst_n AND a registered flush_n.
- res_valid  out  1  datapath outputs this cycle belong to a real beat.
- res_owner  out  $clog2(NUM_REQ)  requester index of that beat.
- res_last  out  1  that beat was the final beat of its burst.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, req_ready=0, dp_stream=0, flush_n=1, res_valid=0, res_owner=0, res_last=0, busy=0, rr_ptr=NUM_REQ-1, beat_cnt=0.
- dp_rst_n follows rst_n combinationally low, so the datapath resets with the scheduler.
- States: IDLE -> STREAM -> DRAIN -> FLUSH -> IDLE.
- IDLE:
  - dp_stream=0.
  - If any req_valid: grant the first valid index searching upward from rr_ptr+1 (wrap modulo NUM_REQ).
  - Register owner, set rr_ptr=owner, go to STREAM next cycle.
  - No request: stay in IDLE.
- STREAM:
  - req_ready[owner]=1; all other ready bits 0.
  - Transfer when req_valid[owner]&&req_ready[owner].
  - On transfer: next-cycle dp_stream=req_data[owner], beat tag valid=1, beat_cnt++.
  - No transfer: next-cycle dp_stream=0, tag valid=0 (bubble); remain in STREAM, no timeout.
  - Exit to DRAIN after the transfer carrying req_last[owner], or the transfer making beat_cnt==BURST_MAX; req_ready drops in the same cycle as that exit.
  - A BURST_MAX-truncated burst sets res_last on its final beat.
  - The requester continues in a later grant.
- DRAIN:
  - dp_stream=0, tag valid=0, for DRAIN_CYCLES cycles (counter), then FLUSH.
- FLUSH:
  - Exactly one cycle: flush_n register=0, so dp_rst_n=0 for that cycle, clearing all datapath stages.
  - beat_cnt=0, then IDLE.
  - Arbitration cannot occur in FLUSH.
- Latency:
  - Word accepted in cycle N -> dp_stream in N+1 -> datapath outputs valid in N+2.
  - res_valid/res_owner/res_last asserted in N+2; the tag pipeline is 2 flops deep.
- Fairness: after requester k finishes, k has lowest priority at the next IDLE arbitration.
- Simultaneous last and BURST_MAX on one beat: single DRAIN entry; res_last=1.
- req_valid on non-owners during STREAM/DRAIN/FLUSH is ignored; their data is never sampled.
- Owner deasserting req_valid mid-burst: bubbles only; the grant is held until last or BURST_MAX.
- Reset mid-burst: the tag pipeline clears, so in-flight beats never raise res_valid after reset.

Optional Feature:
- Macro ZETA_SCHED_PRIO0_EN.
- Defined: requester 0 is high priority. In IDLE, req_valid[0]=1 always wins; others use round-robin among 1..NUM_REQ-1. rr_ptr is not updated when requester 0 wins.
- Undefined: pure round-robin over all requesters.

Test Plan:
- Single burst: req 0 sends 3 words 0x0001,0x0002,0x0003 with last on the 3rd -> req_ready[0] high 3 beats; res_valid high cycles N+2..N+4 with res_owner=0; res_last on the 3rd; dp_rst_n low exactly one cycle, DRAIN_CYCLES+1 cycles after the final accept.
- Round-robin: req 0..3 all valid continuously, 1-beat bursts -> grant order 0,1,2,3,0; the second burst of req 0 produces the same datapath outputs as its first, confirming no carry-over from the flush.
- BURST_MAX truncation: req 2 streams 10 words without last -> 8 accepted, res_last on the 8th, DRAIN/FLUSH, then req 2 regranted (sole requester) for the remaining 2.
- Bubbles: owner drops valid for 2 cycles mid-burst -> dp_stream=0 and res_valid=0 for exactly 2 cycles; burst continues.
- Reset mid-burst: rst_n low during beat 2 -> all outputs at reset values; no res_valid for dropped beats after release; first grant after reset goes to requester 0.
- ZETA_SCHED_PRIO0_EN defined: req 1 and req 0 both valid at IDLE -> req 0 granted, even immediately after its own burst.

Source files
------------

// File: rtl/zeta_stream_sched.sv
// Burst-granting round-robin scheduler that time-shares one 3-stage feedback datapath.
// Optional macro ZETA_SCHED_PRIO0_EN makes requester 0 win every IDLE arbitration.
module zeta_stream_sched #(
  parameter int WIDTH        = 16,
  parameter int NUM_REQ      = 4,
  parameter int BURST_MAX    = 8,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [WIDTH-1:0]           dp_stream,
  output logic                       dp_rst_n,
  output logic                       res_valid,
  output logic [$clog2(NUM_REQ)-1:0] res_owner,
  output logic                       res_last,
  output logic                       busy
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [7:0]    BMAX       = 8'(BURST_MAX);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FLUSH} state_t;

  state_t           state, state_nxt;
  logic [OW-1:0]    owner, rr_ptr, grant_idx, cand;
  logic             grant_found;
  logic [7:0]       beat_cnt;
  logic [DW-1:0]    drain_cnt;
  logic             xfer, beat_cap, beat_last;
  logic [WIDTH-1:0] owner_data;
  logic             flush_n;
  logic             tag_valid, tag_last;
  logic [OW-1:0]    tag_owner;

  // Search upward from the requester after the last winner; the lowest offset wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = OW'((int'(rr_ptr) + off) % NUM_REQ);
`ifdef ZETA_SCHED_PRIO0_EN
      if (req_valid[cand] && (cand != '0)) begin
`else
      if (req_valid[cand]) begin
`endif
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
`ifdef ZETA_SCHED_PRIO0_EN
    if (req_valid[0]) begin
      grant_found = 1'b1;
      grant_idx   = '0;
    end
`endif
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    xfer       = 1'b0;
    owner_data = req_data[int'(owner)*WIDTH +: WIDTH];
    beat_cap   = ((beat_cnt + 8'd1) == BMAX);
    beat_last  = req_last[owner] | beat_cap;
    case (state)
      IDLE:   if (grant_found) state_nxt = STREAM;
      STREAM: begin
        req_ready[owner] = 1'b1;
        xfer             = req_valid[owner];
        if (xfer && beat_last) state_nxt = DRAIN;
      end
      DRAIN:  if (drain_cnt == DRAIN_LAST) state_nxt = FLUSH;
      FLUSH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Stream word and its tag travel together; the tag is delayed once more to meet the datapath output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_stream <= '0;
      flush_n   <= 1'b1;
      tag_valid <= 1'b0;
      tag_last  <= 1'b0;
      tag_owner <= '0;
      res_valid <= 1'b0;
      res_last  <= 1'b0;
      res_owner <= '0;
      owner     <= '0;
      rr_ptr    <= OW'(NUM_REQ - 1);
      beat_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      dp_stream <= xfer ? owner_data : '0;
      tag_valid <= xfer;
      tag_last  <= xfer & beat_last;
      tag_owner <= owner;
      res_valid <= tag_valid;
      res_last  <= tag_last;
      res_owner <= tag_owner;
      flush_n   <= (state_nxt != FLUSH);
      case (state)
        IDLE: if (grant_found) begin
          owner <= grant_idx;
`ifdef ZETA_SCHED_PRIO0_EN
          if (grant_idx != '0) rr_ptr <= grant_idx;
`else
          rr_ptr <= grant_idx;
`endif
        end
        STREAM: begin
          drain_cnt <= '0;
          if (xfer) beat_cnt <= beat_cnt + 8'd1;
        end
        DRAIN: drain_cnt <= drain_cnt + 1'b1;
        FLUSH: beat_cnt <= '0;
        default: ;
      endcase
    end
  end

  assign dp_rst_n = rst_n & flush_n;
  assign busy     = (state != IDLE);

endmodule
